// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: mode_e state/mode encoding, SOS sequence constants, sos_bit() lookup.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_BLINK = 2'b01,
        ST_CHASE = 2'b10,
        ST_SOS   = 2'b11
    } mode_e;

    localparam int SOS_LEN   = 34;
    localparam int SOS_IDX_W = $clog2(SOS_LEN);

    // S, letter gap, O, letter gap, S, word gap. Step 0 is the MSB.
    localparam logic [SOS_LEN-1:0] SOS_PATTERN = 34'b1010100011101110111000101010000000;

    // LED level for SOS step 'step'; steps beyond the sequence read as dark.
    function automatic logic sos_bit(input logic [SOS_IDX_W-1:0] step);
        logic [SOS_IDX_W-1:0] pos;
        logic                 res;
        pos = SOS_IDX_W'(SOS_LEN - 1) - step;
        if (step >= SOS_IDX_W'(SOS_LEN)) begin
            res = 1'b0;
        end else begin
            res = SOS_PATTERN[pos];
        end
        return res;
    endfunction

endpackage

// File: rtl/toggle_edge_detect.sv
// Converts every edge (rise or fall) of a same-domain level into a one-cycle pulse.
// Latency: combinational pulse in the cycle the new level is seen.
// Backpressure: none; every edge produces exactly one pulse.
//
// Ports: CLK_50MHZ clock, RESET sync active-high, din level input, pulse = din ^ previous din.
module toggle_edge_detect (
    input  logic CLK_50MHZ,
    input  logic RESET,
    input  logic din,
    output logic pulse
);

    logic blink_prev_q;

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            blink_prev_q <= 1'b0;
        end else begin
            blink_prev_q <= din;
        end
    end

    assign pulse = din ^ blink_prev_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps an LED pattern (off / blink / chase / SOS) on every blink_en toggle.
// Latency: a tick seen in cycle N is visible on LEDR/pattern_wrap in cycle N+1.
// Backpressure: none; hold=1 discards ticks (no catch-up burst on release).
//
// Ports: CLK_50MHZ clock, RESET sync active-high, blink_en divider toggle,
//        mode pattern select (sampled every cycle), hold freeze,
//        LEDR registered LED drive, pattern_wrap one-cycle end-of-pattern pulse.
module led_pattern_sequencer
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 10,
    parameter int SOS_LEN  = 34
) (
    input  logic                CLK_50MHZ,
    input  logic                RESET,
    input  logic                blink_en,
    input  logic [1:0]          mode,
    input  logic                hold,
    output logic [NUM_LEDS-1:0] LEDR,
    output logic                pattern_wrap
);

    localparam int CHASE_W = $clog2(NUM_LEDS);
    localparam int SOS_W   = $clog2(SOS_LEN);
    // One index register serves both chase and SOS, so size it for the larger.
    localparam int IDX_W   = (CHASE_W > SOS_W) ? CHASE_W : SOS_W;

    localparam logic [IDX_W-1:0] CHASE_LAST = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0] SOS_LAST   = IDX_W'(SOS_LEN - 1);

    mode_e               state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] ledr_q, ledr_d;
    logic                wrap_q, wrap_d;

    logic                tick;
    logic                step_en;
    mode_e               mode_sel;
    logic [IDX_W-1:0]    idx_inc;

    function automatic logic [NUM_LEDS-1:0] chase_word(input logic [IDX_W-1:0] i);
        return {{(NUM_LEDS-1){1'b0}}, 1'b1} << i;
    endfunction

    function automatic logic [NUM_LEDS-1:0] sos_word(input logic [IDX_W-1:0] i);
        return {NUM_LEDS{sos_bit(SOS_IDX_W'(i))}};
    endfunction

    toggle_edge_detect u_tick (
        .CLK_50MHZ (CLK_50MHZ),
        .RESET     (RESET),
        .din       (blink_en),
        .pulse     (tick)
    );

    assign mode_sel = mode_e'(mode);
    assign step_en  = tick & ~hold;
    assign idx_inc  = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        ledr_d  = ledr_q;
        wrap_d  = 1'b0;

        if (mode_sel != state_q) begin
            // Restart takes priority over both a coincident tick and hold.
            state_d = mode_sel;
            idx_d   = '0;
            phase_d = 1'b0;
            case (mode_sel)
                ST_CHASE: ledr_d = chase_word('0);
                ST_SOS:   ledr_d = sos_word('0);
                default:  ledr_d = '0;
            endcase
        end else begin
            case (state_q)
                ST_OFF: begin
                    idx_d   = '0;
                    phase_d = 1'b0;
                    ledr_d  = '0;
                end
                ST_BLINK: begin
                    idx_d = '0;
                    if (step_en) begin
                        phase_d = ~phase_q;
                        ledr_d  = {NUM_LEDS{~phase_q}};
                        wrap_d  = phase_q;
                    end
                end
                ST_CHASE: begin
                    if (idx_q > CHASE_LAST) begin
                        // Unreachable recovery: snap back to the first LED silently.
                        idx_d  = '0;
                        ledr_d = chase_word('0);
                    end else if (step_en) begin
                        if (idx_q == CHASE_LAST) begin
                            idx_d  = '0;
                            ledr_d = chase_word('0);
                            wrap_d = 1'b1;
                        end else begin
                            idx_d  = idx_inc;
                            ledr_d = chase_word(idx_inc);
                        end
                    end
                end
                ST_SOS: begin
                    if (idx_q > SOS_LAST) begin
                        idx_d  = '0;
                        ledr_d = sos_word('0);
                    end else if (step_en) begin
                        if (idx_q == SOS_LAST) begin
                            idx_d  = '0;
                            ledr_d = sos_word('0);
                            wrap_d = 1'b1;
                        end else begin
                            idx_d  = idx_inc;
                            ledr_d = sos_word(idx_inc);
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    ledr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            phase_q <= 1'b0;
            ledr_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            ledr_q  <= ledr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign LEDR         = ledr_q;
    assign pattern_wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: vector table, directed multi-cycle
// sequences and a randomized run against a step-counting reference model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that point too.
module tb_led_pattern_sequencer;

    localparam int N     = 10;
    localparam int SOS_N = 34;

    logic         clk = 1'b0;
    logic         rst;
    logic         be;
    logic [1:0]   md;
    logic         hl;
    logic [N-1:0] ledr;
    logic         wrap;

    always #10 clk = ~clk;

    led_pattern_sequencer #(.NUM_LEDS(N), .SOS_LEN(SOS_N)) dut (
        .CLK_50MHZ    (clk),
        .RESET        (rst),
        .blink_en     (be),
        .mode         (md),
        .hold         (hl),
        .LEDR         (ledr),
        .pattern_wrap (wrap)
    );

    int vectors     = 0;
    int miscompares = 0;

    // SOS on/off levels per step, built from Morse timing rules.
    int sos_q[$];

    // Reference model: current mode and number of accepted ticks since entry.
    int           m_mode;
    int           m_ticks;
    logic         m_prev;
    logic [N-1:0] m_led;
    logic         m_wrap;
    logic         cur_be;

    typedef struct {
        logic         r;
        logic         b;
        logic [1:0]   m;
        logic         h;
        logic [N-1:0] led;
        logic         w;
    } vec_t;

    vec_t tbl[20];

    function automatic int period(input int mm);
        case (mm)
            1:       return 2;
            2:       return N;
            3:       return SOS_N;
            default: return 1;
        endcase
    endfunction

    function automatic logic [N-1:0] model_led(input int mm, input int step);
        logic [N-1:0] one;
        one = 1;
        case (mm)
            1:       return (step % 2 == 1) ? '1 : '0;
            2:       return one << step;
            3:       return (sos_q[step] != 0) ? '1 : '0;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [N-1:0] el, input logic ew);
        vectors++;
        if (ledr !== el || wrap !== ew) begin
            miscompares++;
            $display("FAIL %s: got LEDR=%h wrap=%b, want LEDR=%h wrap=%b", name, ledr, wrap, el, ew);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, advance the model and compare.
    task automatic cyc(input logic r, input logic b, input logic [1:0] m, input logic h);
        logic tk;
        rst = r; be = b; md = m; hl = h;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0; m_ticks = 0; m_prev = 1'b0; m_wrap = 1'b0;
        end else begin
            tk     = b ^ m_prev;
            m_prev = b;
            m_wrap = 1'b0;
            if (int'(m) != m_mode) begin
                m_mode  = int'(m);
                m_ticks = 0;
            end else if (tk && !h && m_mode != 0) begin
                m_ticks++;
                m_wrap = (m_ticks % period(m_mode)) == 0;
            end
        end
        m_led = model_led(m_mode, m_ticks % period(m_mode));
        chk("model", m_led, m_wrap);
    endtask

    task automatic idle(input int n, input logic [1:0] m, input logic h);
        for (int k = 0; k < n; k++) cyc(1'b0, cur_be, m, h);
    endtask

    initial begin
        int wraps;
        string sym;

        // Build SOS: dot=1 on, dash=3 on, gap 1 between symbols, 3 between letters, 7 at end.
        for (int li = 0; li < 3; li++) begin
            sym = (li == 1) ? "---" : "...";
            for (int si = 0; si < 3; si++) begin
                if (si > 0) sos_q.push_back(0);
                if (sym[si] == "-") begin
                    repeat (3) sos_q.push_back(1);
                end else begin
                    sos_q.push_back(1);
                end
            end
            repeat ((li == 2) ? 7 : 3) sos_q.push_back(0);
        end

        m_mode = 0; m_ticks = 0; m_prev = 1'b0; m_led = '0; m_wrap = 1'b0;

        //           rst   be    mode   hold  LEDR      wrap
        tbl[0]  = '{1'b1, 1'b0, 2'd3, 1'b0, 10'h000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'd3, 1'b0, 10'h000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd3, 1'b0, 10'h000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 10'h000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 10'h3FF, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 10'h3FF, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 10'h000, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 2'd1, 1'b0, 10'h000, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 10'h3FF, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'd1, 1'b0, 10'h000, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'd1, 1'b0, 10'h000, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'd2, 1'b0, 10'h001, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 10'h001, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 2'd2, 1'b0, 10'h002, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 2'd2, 1'b1, 10'h002, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 2'd2, 1'b1, 10'h002, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 2'd2, 1'b0, 10'h002, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 2'd2, 1'b0, 10'h004, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 2'd0, 1'b0, 10'h000, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 2'd0, 1'b0, 10'h000, 1'b0};

        // Reset, blink, chase entry with coincident edge, hold, off.
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].r, tbl[i].b, tbl[i].m, tbl[i].h);
            chk($sformatf("tbl%0d", i), tbl[i].led, tbl[i].w);
        end
        cur_be = 1'b1;

        // Chase: 10 edges 20 cycles apart, single wrap on the 10th.
        cyc(1'b0, cur_be, 2'd2, 1'b0);
        chk("chase_entry", 10'h001, 1'b0);
        wraps = 0;
        for (int i = 1; i <= 10; i++) begin
            cur_be = ~cur_be;
            cyc(1'b0, cur_be, 2'd2, 1'b0);
            chk($sformatf("chase_edge%0d", i), (i == 10) ? 10'h001 : (10'h001 << i), (i == 10));
            wraps += int'(wrap);
            for (int g = 0; g < 19; g++) begin
                cyc(1'b0, cur_be, 2'd2, 1'b0);
                wraps += int'(wrap);
            end
        end
        chk_int("chase_wrap_count", wraps, 1);

        // SOS: 35 edges, wrap on edge 34, edge 35 lands on step 1.
        cyc(1'b0, cur_be, 2'd3, 1'b0);
        chk("sos_entry", 10'h3FF, 1'b0);
        for (int i = 1; i <= 35; i++) begin
            cur_be = ~cur_be;
            cyc(1'b0, cur_be, 2'd3, 1'b0);
            chk($sformatf("sos_edge%0d", i), (sos_q[i % SOS_N] != 0) ? 10'h3FF : 10'h000, (i == SOS_N));
            if (i == 3) chk("sos_step3", 10'h000, 1'b0);
            idle(2, 2'd3, 1'b0);
        end

        // Hold and mode priority.
        cyc(1'b0, cur_be, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cur_be = ~cur_be;
            cyc(1'b0, cur_be, 2'd2, 1'b0);
            idle(2, 2'd2, 1'b0);
        end
        chk("chase_idx4", 10'h010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cur_be = ~cur_be;
            cyc(1'b0, cur_be, 2'd2, 1'b1);
            chk($sformatf("hold_edge%0d", i), 10'h010, 1'b0);
            idle(2, 2'd2, 1'b1);
        end
        cyc(1'b0, cur_be, 2'd2, 1'b0);
        chk("hold_release_no_burst", 10'h010, 1'b0);
        cur_be = ~cur_be;
        cyc(1'b0, cur_be, 2'd2, 1'b0);
        chk("hold_release_edge", 10'h020, 1'b0);
        cur_be = ~cur_be;
        cyc(1'b0, cur_be, 2'd3, 1'b0);
        chk("mode_beats_edge", 10'h3FF, 1'b0);
        cur_be = ~cur_be;
        cyc(1'b0, cur_be, 2'd3, 1'b0);
        chk("sos_restart_step1", 10'h000, 1'b0);
        cyc(1'b0, cur_be, 2'd2, 1'b1);
        chk("mode_beats_hold", 10'h001, 1'b0);

        // Reset mid-SOS at step 20, then re-entry on the first non-reset cycle.
        cyc(1'b0, cur_be, 2'd3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cur_be = ~cur_be;
            cyc(1'b0, cur_be, 2'd3, 1'b0);
        end
        chk("sos_step20", 10'h000, 1'b0);
        cyc(1'b1, cur_be, 2'd3, 1'b0);
        chk("reset_mid", 10'h000, 1'b0);
        cyc(1'b0, cur_be, 2'd3, 1'b0);
        chk("reset_reentry", 10'h3FF, 1'b0);
        cur_be = ~cur_be;
        cyc(1'b0, cur_be, 2'd3, 1'b0);
        chk("reset_then_step1", 10'h000, 1'b0);

        // Randomized run against the model.
        md = 2'd3;
        hl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            logic r;
            logic [1:0] m;
            logic h;
            r = ($urandom_range(0, 249) == 0);
            m = md;
            h = hl;
            if ($urandom_range(0, 149) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) h = ~h;
            if (i >= 2000 || $urandom_range(0, 2) == 0) cur_be = ~cur_be;
            cyc(r, cur_be, m, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
